// File: rtl/mem_stream_ctrl_if.sv
// Command, write-stream, read-stream and memory-port bundle for mem_stream_ctrl.
// master = controller side, slave = host/datapath/memory side.
interface mem_stream_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [AW:0]      cmd_len;

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_din;
  logic [WIDTH-1:0] mem_dout;

  logic             busy;
  logic             done;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  s_data, s_valid,
    input  m_ready,
    input  mem_dout,
    output cmd_ready, s_ready,
    output m_data, m_valid, m_last,
    output mem_en, mem_we, mem_addr, mem_din,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output s_data, s_valid,
    output m_ready,
    output mem_dout,
    input  cmd_ready, s_ready,
    input  m_data, m_valid, m_last,
    input  mem_en, mem_we, mem_addr, mem_din,
    input  busy, done
  );
endinterface

// File: rtl/mem_stream_ctrl.sv
// Single-port memory initiator: WRITE sinks a valid/ready stream into consecutive
// words, READ streams consecutive words out through a 2-entry skid FIFO.
module mem_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input logic              clk,
  input logic              rst,
  mem_stream_ctrl_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_TOP = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    addr_next;
  logic [AW:0]      rem_q;
  logic             done_q;

  logic             inflight_q;
  logic             inflight_last_q;
  logic [WIDTH-1:0] fifo_data [2];
  logic             fifo_last [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;

  logic             cmd_ready;
  logic             s_ready;
  logic             mem_en;
  logic             mem_we;
  logic             accept;
  logic             wr_beat;
  logic             rd_issue;
  logic             finish;
  logic             m_valid;
  logic             head_last;
  logic             pop;
  logic [2:0]       occ;

  assign m_valid   = (count_q != 2'd0);
  assign head_last = fifo_last[rd_ptr_q];
  assign pop       = m_valid & bus.m_ready;
  // Words buffered plus the read still in the memory pipe, after this cycle's pop.
  assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign addr_next = (addr_q == ADDR_TOP) ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    accept    = 1'b0;
    wr_beat   = 1'b0;
    rd_issue  = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          accept = 1'b1;
          if (bus.cmd_len != '0) state_d = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          wr_beat = 1'b1;
          mem_en  = 1'b1;
          mem_we  = 1'b1;
          if (rem_q == LEN_ONE) begin
            state_d = IDLE;
            finish  = 1'b1;
          end
        end
      end
      READ: begin
        if (rem_q != '0 && occ < 3'd2) begin
          rd_issue = 1'b1;
          mem_en   = 1'b1;
        end
        if (pop && head_last) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish | (accept & (bus.cmd_len == '0));
      if (accept) begin
        addr_q <= bus.cmd_addr;
        rem_q  <= bus.cmd_len;
      end else if (wr_beat | rd_issue) begin
        addr_q <= addr_next;
        rem_q  <= rem_q - LEN_ONE;
      end
    end
  end

  // Read data returns one cycle after issue; the last flag travels with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue & (rem_q == LEN_ONE);
      if (inflight_q) begin
        fifo_data[wr_ptr_q] <= bus.mem_dout;
        fifo_last[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({inflight_q, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = ~cmd_ready;
  assign bus.done      = done_q;
  assign bus.s_ready   = s_ready;
  assign bus.m_data    = fifo_data[rd_ptr_q];
  assign bus.m_valid   = m_valid;
  assign bus.m_last    = m_valid & head_last;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = bus.s_data;
endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Directed bench for mem_stream_ctrl: command table plus reset-abort sequence,
// with a write-first 1-cycle-latency memory and a shadow copy of its contents.
module tb_mem_stream_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int NV    = 9;

  typedef struct {
    bit         wr;
    int         addr;
    int         len;
    logic [7:0] mask;     // s_valid (WRITE) or m_ready (READ) pattern, bit = cycle % 8
    logic [7:0] dbase;
    logic [7:0] dstep;
    int         exp_cyc;  // cycle of done after accept (0 = not fixed)
  } vec_t;

  logic clk;
  logic rst;
  logic mem_clr;
  logic [7:0] mem    [DEPTH];
  logic [7:0] shadow [DEPTH];
  vec_t vecs [NV];
  int n_cmp;
  int n_bad;

  mem_stream_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mem_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout      <= bus.mem_din;
      end else begin
        bus.mem_dout <= mem[bus.mem_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_busy",      32'(bus.busy), 0);
    check("rst_done",      32'(bus.done), 0);
    check("rst_s_ready",   32'(bus.s_ready), 0);
    check("rst_m_valid",   32'(bus.m_valid), 0);
    check("rst_m_last",    32'(bus.m_last), 0);
    check("rst_m_data",    32'(bus.m_data), 0);
    check("rst_mem_en",    32'(bus.mem_en), 0);
    check("rst_mem_we",    32'(bus.mem_we), 0);
    check("rst_mem_addr",  32'(bus.mem_addr), 0);
  endtask

  task automatic run_cmd(input vec_t v);
    int unsigned issued, popped, beats, first_v, exp_addr;
    bit          prev_hold, fin;
    logic [7:0]  prev_data, din;
    issued = 0; popped = 0; beats = 0; first_v = 0;
    prev_hold = 0; prev_data = 0; fin = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = 6'(v.addr);
    bus.cmd_len   = 7'(v.len);
    @(negedge clk);
    check("cmd_ready_accept", 32'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      din = 8'(v.dbase + 8'(beats) * v.dstep);
      bus.s_data  = din;
      bus.s_valid = v.wr && (int'(beats) < v.len) && v.mask[cyc % 8];
      bus.m_ready = !v.wr && v.mask[cyc % 8];
      @(negedge clk);
      if (v.wr && bus.s_valid) check("wr_beat_en", 32'(bus.mem_en & bus.s_ready), 1);
      if (bus.mem_en) begin
        exp_addr = (v.addr + issued) % DEPTH;
        check("mem_addr", 32'(bus.mem_addr), exp_addr);
        check("mem_we", 32'(bus.mem_we), 32'(v.wr));
        if (v.wr) begin
          check("mem_din", 32'(bus.mem_din), 32'(din));
          shadow[exp_addr] = din;
          beats++;
        end
        issued++;
      end else begin
        check("we_without_en", 32'(bus.mem_we), 0);
      end
      if (prev_hold) begin
        check("m_valid_hold", 32'(bus.m_valid), 1);
        check("m_data_hold", 32'(bus.m_data), 32'(prev_data));
      end
      if (bus.m_valid && first_v == 0) first_v = cyc;
      if (bus.m_valid && bus.m_ready) begin
        check("m_data", 32'(bus.m_data), 32'(shadow[(v.addr + popped) % DEPTH]));
        check("m_last", 32'(bus.m_last), 32'(int'(popped) == v.len - 1));
        popped++;
      end
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
      if (!v.wr) check("outstanding_le2", 32'(issued - popped <= 2), 1);
      if (bus.done) begin
        fin = 1;
        if (v.exp_cyc != 0) check("done_cycle", cyc, v.exp_cyc);
        check("cmd_ready_at_done", 32'(bus.cmd_ready), 1);
        check("busy_at_done", 32'(bus.busy), 0);
        check("mem_accesses", issued, v.len);
        if (!v.wr) check("words_popped", popped, v.len);
        if (!v.wr && v.mask == 8'hff && v.len != 0) check("first_valid_cycle", first_v, 3);
      end
      @(posedge clk); #1;
    end
    check("done_seen", 32'(fin), 1);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 0; rst = 1; mem_clr = 1;
    n_cmp = 0; n_bad = 0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.s_data = '0; bus.s_valid = 0; bus.m_ready = 0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = 8'h00;

    //          wr addr len  mask        dbase  dstep  exp_cyc
    vecs[0] = '{1,  0,  4, 8'hff,       8'h11, 8'h11, 5};
    vecs[1] = '{0,  0,  4, 8'hff,       8'h00, 8'h00, 7};
    vecs[2] = '{1, 62,  4, 8'hff,       8'ha1, 8'h01, 5};
    vecs[3] = '{0, 62,  4, 8'hff,       8'h00, 8'h00, 7};
    vecs[4] = '{1, 10,  8, 8'b10110110, 8'h30, 8'h03, 0};
    vecs[5] = '{0, 10,  8, 8'b01101001, 8'h00, 8'h00, 0};
    vecs[6] = '{0,  5,  0, 8'hff,       8'h00, 8'h00, 1};
    vecs[7] = '{1,  5,  0, 8'hff,       8'h77, 8'h01, 1};
    vecs[8] = '{0,  0, 64, 8'hff,       8'h00, 8'h00, 67};

    @(posedge clk); #1;
    @(negedge clk);
    check_reset_vals();
    rst = 0; mem_clr = 0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_cmd(vecs[i]);

    // Abort a stalled READ with an asynchronous reset between clock edges.
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 6'd20; bus.cmd_len = 7'd8;
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1 check_reset_vals();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 0;
    @(posedge clk); #1;
    run_cmd('{1, 5, 1, 8'hff, 8'h5a, 8'h00, 2});
    run_cmd('{0, 5, 1, 8'hff, 8'h00, 8'h00, 4});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
